alu_operand_issue: RTL and testbench
====================================

ALU_OPERAND_ISSUE -- requirements
Module: alu_operand_issue

Interface
REQ-001 SHALL have parameter ACTION_LEN, default 25, action word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 48, container/ALU operand width.
REQ-003 SHALL have parameter NUM_CONT, fixed 8, number of PHV containers; index width 3.
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles waiting for an ALU result.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  block can accept a request.
REQ-009 SHALL have port req_action  input  ACTION_LEN  action word: [24:21] opcode, [20:18] op1/dest index, [17:15] op2 index, [14:0] immediate.
REQ-010 SHALL have port req_phv  input  NUM_CONT*DATA_WIDTH  PHV; container i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port alu_action  output  ACTION_LEN  action to ALU.
REQ-012 SHALL have port alu_action_valid  output  1  one-cycle issue strobe to ALU.
REQ-013 SHALL have port alu_operand_1 / alu_operand_2  output  DATA_WIDTH each  ALU operands.
REQ-014 SHALL have port alu_container / alu_container_valid  input  DATA_WIDTH / 1  ALU result and its one-cycle valid.
REQ-015 SHALL have port rsp_valid / rsp_ready  output / input  1 each  response handshake.
REQ-016 SHALL have port rsp_phv  output  NUM_CONT*DATA_WIDTH  updated PHV.
REQ-017 SHALL have port rsp_timeout  output  1  response produced by timeout, not ALU result.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, DONE; one request in flight max.
REQ-019 SHALL drive req_ready=1 only in IDLE; accept on req_valid&&req_ready at edge k, latching action and PHV, entering ISSUE.
REQ-020 SHALL register at acceptance alu_action=req_action, alu_operand_1=container[op1 idx], alu_operand_2 = opcode[3]==1 ? zero-extended immediate : container[op2 idx]; held stable until next acceptance.
REQ-021 SHALL assert alu_action_valid for exactly cycle k+1 (ISSUE), then enter WAIT with wait counter cleared.
REQ-022 SHALL, in WAIT, on alu_container_valid write alu_container into latched container[op1 idx], all other containers unchanged, rsp_timeout=0, enter DONE.
REQ-023 SHALL, in WAIT, increment wait counter each cycle; if TIMEOUT WAIT cycles elapse without alu_container_valid, enter DONE with PHV unchanged and rsp_timeout=1.
REQ-024 SHALL give alu_container_valid priority when it coincides with the timeout cycle.
REQ-025 SHALL ignore alu_container_valid in IDLE, ISSUE and DONE.
REQ-026 SHALL assert rsp_valid in DONE; rsp_phv and rsp_timeout stable while rsp_valid && !rsp_ready.
REQ-027 SHALL on rsp_valid&&rsp_ready return to IDLE next cycle; no request accepted in that same cycle.
REQ-028 SHALL produce rsp_valid the cycle after alu_container_valid (ALU latency L gives request-to-response L+2 cycles).

Reset
REQ-029 SHALL on rst_n low set state IDLE, counter 0, all outputs 0 (req_ready becomes 1 after release since IDLE).
REQ-030 SHALL on reset mid-operation discard the in-flight request with no response; ALU results arriving after release are ignored.

Verification
REQ-031 add: c0=5, c1=3, opcode 0001, op1=0, op2=1, ALU model latency 2 returns 8 -> operands 5/3, rsp_phv c0=8, others unchanged, rsp_timeout=0.
REQ-032 addi: c2=0x20, opcode 1001, op1=2, imm=0x10 -> alu_operand_2=0x10; model returns 0x30 -> rsp_phv c2=0x30.
REQ-033 timeout: ALU silent -> rsp_valid exactly TIMEOUT cycles after WAIT entry plus one, rsp_phv==req_phv, rsp_timeout=1; ALU valid on timeout cycle -> result written, rsp_timeout=0.
REQ-034 backpressure: rsp_ready low 5 cycles -> rsp_phv stable, req_ready=0, second req_valid not accepted until after handshake.
REQ-035 reset during WAIT, then ALU valid -> no rsp_valid, outputs 0; next request completes normally.
REQ-036 spurious alu_container_valid in IDLE -> no state change, no rsp_valid.

Source files
------------

// File: rtl/alu_operand_issue_if.sv
// alu_operand_issue_if: request, ALU issue/result and response signals of the operand issue block.
interface alu_operand_issue_if #(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int NUM_CONT   = 8
);
  logic                           req_valid;
  logic                           req_ready;
  logic [ACTION_LEN-1:0]          req_action;
  logic [NUM_CONT*DATA_WIDTH-1:0] req_phv;
  logic [ACTION_LEN-1:0]          alu_action;
  logic                           alu_action_valid;
  logic [DATA_WIDTH-1:0]          alu_operand_1;
  logic [DATA_WIDTH-1:0]          alu_operand_2;
  logic [DATA_WIDTH-1:0]          alu_container;
  logic                           alu_container_valid;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [NUM_CONT*DATA_WIDTH-1:0] rsp_phv;
  logic                           rsp_timeout;
  modport slave (
    input  req_valid, req_action, req_phv, alu_container, alu_container_valid, rsp_ready,
    output req_ready, alu_action, alu_action_valid, alu_operand_1, alu_operand_2,
           rsp_valid, rsp_phv, rsp_timeout
  );
  modport master (
    output req_valid, req_action, req_phv, alu_container, alu_container_valid, rsp_ready,
    input  req_ready, alu_action, alu_action_valid, alu_operand_1, alu_operand_2,
           rsp_valid, rsp_phv, rsp_timeout
  );
endinterface

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: latches one action+PHV, issues operands to the ALU, writes the result back or times out.
module alu_operand_issue #(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int NUM_CONT   = 8,
  parameter int TIMEOUT    = 16
) (
  input logic clk,
  input logic rst_n,
  alu_operand_issue_if.slave bus
);
  localparam int IW = $clog2(NUM_CONT);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [IW-1:0] dst, a_idx, b_idx;
  logic [14:0] imm;
  logic imm_sel, accept, hit, expire;
  assign imm_sel = bus.req_action[ACTION_LEN-1];
  assign a_idx = bus.req_action[ACTION_LEN-5 -: IW];
  assign b_idx = bus.req_action[ACTION_LEN-8 -: IW];
  assign imm = bus.req_action[14:0];
  assign accept = bus.req_valid && state == IDLE;
  assign hit = state == WAIT && bus.alu_container_valid;
  assign expire = state == WAIT && cnt == LAST;
  assign bus.req_ready = rst_n && state == IDLE;
  assign bus.alu_action_valid = state == ISSUE;
  assign bus.rsp_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state == IDLE  ? (accept ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (hit || expire ? DONE : WAIT) :
                               (bus.rsp_ready ? IDLE : DONE);
  end
  // A result arriving on the final WAIT cycle wins over the timeout.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      dst <= '0;
      bus.alu_action <= '0;
      bus.alu_operand_1 <= '0;
      bus.alu_operand_2 <= '0;
      bus.rsp_phv <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (accept) begin
        dst <= a_idx;
        bus.alu_action <= bus.req_action;
        bus.alu_operand_1 <= bus.req_phv[a_idx*DATA_WIDTH +: DATA_WIDTH];
        bus.alu_operand_2 <= imm_sel ? DATA_WIDTH'(imm) : bus.req_phv[b_idx*DATA_WIDTH +: DATA_WIDTH];
        bus.rsp_phv <= bus.req_phv;
        bus.rsp_timeout <= 1'b0;
      end
      if (hit) bus.rsp_phv[dst*DATA_WIDTH +: DATA_WIDTH] <= bus.alu_container;
      else if (expire) bus.rsp_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue: table-driven vectors plus directed backpressure, reset and spurious-result sequences.
module tb_alu_operand_issue;
  localparam int AL = 25, DW = 48, NC = 8, TO = 16, PW = NC * DW;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  alu_operand_issue_if #(.ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC)) bus();
  alu_operand_issue #(.ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct {
    logic [AL-1:0] action;
    logic [PW-1:0] phv;
    logic [DW-1:0] res;
    int            lat;
    logic [DW-1:0] e_op1;
    logic [DW-1:0] e_op2;
    logic [PW-1:0] e_phv;
    logic          e_to;
  } vec_t;
  vec_t vecs[6];
  int checks = 0;
  int fails = 0;
  logic [PW-1:0] base;
  int n;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [PW-1:0] put(input logic [PW-1:0] p, input int i, input logic [DW-1:0] v);
    p[i*DW +: DW] = v;
    return p;
  endfunction
  function automatic logic [AL-1:0] mk(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [14:0] imm);
    return {op, a, b, imm};
  endfunction
  // ALU result is driven during cycle `lat` counted from the issue cycle; lat 0 means silent.
  task automatic wait_rsp(input int lat, input logic [DW-1:0] res, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      tick;
      bus.alu_container_valid = (i == lat);
      bus.alu_container = res;
      if (bus.rsp_valid) begin
        cyc = i;
        break;
      end
    end
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    bus.req_valid = 1'b1;
    bus.req_action = v.action;
    bus.req_phv = v.phv;
    check({tag, " req_ready"}, PW'(bus.req_ready), PW'(1'b1));
    tick;
    bus.req_valid = 1'b0;
    check({tag, " issue_strobe"}, PW'(bus.alu_action_valid), PW'(1'b1));
    check({tag, " alu_action"}, PW'(bus.alu_action), PW'(v.action));
    check({tag, " operand_1"}, PW'(bus.alu_operand_1), PW'(v.e_op1));
    check({tag, " operand_2"}, PW'(bus.alu_operand_2), PW'(v.e_op2));
    wait_rsp(v.lat, v.res, cyc);
    check({tag, " latency"}, PW'(cyc), PW'((v.lat >= 1 && v.lat <= TO) ? v.lat + 1 : TO + 1));
    check({tag, " rsp_phv"}, bus.rsp_phv, v.e_phv);
    check({tag, " rsp_timeout"}, PW'(bus.rsp_timeout), PW'(v.e_to));
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    bus.alu_container_valid = 1'b0;
    check({tag, " rsp_valid_drop"}, PW'(bus.rsp_valid), PW'(1'b0));
    check({tag, " back_to_idle"}, PW'(bus.req_ready), PW'(1'b1));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_action = '0;
    bus.req_phv = '0;
    bus.alu_container = '0;
    bus.alu_container_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    base = '0;
    for (int i = 0; i < NC; i++) base = put(base, i, DW'(48'h1000 + i));
    base = put(base, 0, 48'd5);
    base = put(base, 1, 48'd3);
    base = put(base, 2, 48'h20);
    vecs[0] = '{mk(4'b0001, 3'd0, 3'd1, 15'd0), base, 48'd8, 2, 48'd5, 48'd3, put(base, 0, 48'd8), 1'b0};
    vecs[1] = '{mk(4'b1001, 3'd2, 3'd5, 15'h10), base, 48'h30, 1, 48'h20, 48'h10, put(base, 2, 48'h30), 1'b0};
    vecs[2] = '{mk(4'b0010, 3'd3, 3'd4, 15'd0), base, 48'h77, 0, 48'h1003, 48'h1004, base, 1'b1};
    vecs[3] = '{mk(4'b0011, 3'd7, 3'd6, 15'd0), base, 48'hABCDEF, TO, 48'h1007, 48'h1006, put(base, 7, 48'hABCDEF), 1'b0};
    vecs[4] = '{mk(4'b0100, 3'd5, 3'd2, 15'd0), base, 48'h99, TO + 1, 48'h1005, 48'h20, base, 1'b1};
    vecs[5] = '{mk(4'b1111, 3'd1, 3'd0, 15'h7FFF), base, 48'hFFFF_FFFF_FFFF, 3, 48'd3, 48'h7FFF, put(base, 1, 48'hFFFF_FFFF_FFFF), 1'b0};
    #2 rst_n = 1'b0;
    tick;
    check("reset req_ready", PW'(bus.req_ready), PW'(1'b0));
    check("reset rsp_valid", PW'(bus.rsp_valid), PW'(1'b0));
    check("reset issue_strobe", PW'(bus.alu_action_valid), PW'(1'b0));
    check("reset operand_1", PW'(bus.alu_operand_1), PW'(1'b0));
    check("reset rsp_phv", bus.rsp_phv, PW'(1'b0));
    rst_n = 1'b1;
    tick;
    check("release req_ready", PW'(bus.req_ready), PW'(1'b1));
    bus.alu_container_valid = 1'b1;
    bus.alu_container = 48'hDEAD;
    repeat (3) begin
      tick;
      check("spurious rsp_valid", PW'(bus.rsp_valid), PW'(1'b0));
      check("spurious issue_strobe", PW'(bus.alu_action_valid), PW'(1'b0));
      check("spurious req_ready", PW'(bus.req_ready), PW'(1'b1));
    end
    bus.alu_container_valid = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    bus.req_valid = 1'b1;
    bus.req_action = vecs[0].action;
    bus.req_phv = base;
    tick;
    bus.req_action = vecs[1].action;
    check("bp busy req_ready", PW'(bus.req_ready), PW'(1'b0));
    wait_rsp(2, 48'd8, n);
    check("bp latency", PW'(n), PW'(3));
    repeat (5) begin
      check("bp rsp_valid", PW'(bus.rsp_valid), PW'(1'b1));
      check("bp rsp_phv", bus.rsp_phv, put(base, 0, 48'd8));
      check("bp req_ready", PW'(bus.req_ready), PW'(1'b0));
      check("bp alu_action", PW'(bus.alu_action), PW'(vecs[0].action));
      tick;
    end
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    check("bp idle rsp_valid", PW'(bus.rsp_valid), PW'(1'b0));
    check("bp idle req_ready", PW'(bus.req_ready), PW'(1'b1));
    check("bp no early accept", PW'(bus.alu_action), PW'(vecs[0].action));
    tick;
    bus.req_valid = 1'b0;
    check("bp second strobe", PW'(bus.alu_action_valid), PW'(1'b1));
    check("bp second action", PW'(bus.alu_action), PW'(vecs[1].action));
    check("bp second operand_2", PW'(bus.alu_operand_2), PW'(48'h10));
    wait_rsp(1, 48'h30, n);
    check("bp second rsp_phv", bus.rsp_phv, put(base, 2, 48'h30));
    check("bp second rsp_timeout", PW'(bus.rsp_timeout), PW'(1'b0));
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    bus.alu_container_valid = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_action = vecs[2].action;
    bus.req_phv = base;
    tick;
    bus.req_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("mid reset req_ready", PW'(bus.req_ready), PW'(1'b0));
    check("mid reset rsp_valid", PW'(bus.rsp_valid), PW'(1'b0));
    check("mid reset alu_action", PW'(bus.alu_action), PW'(1'b0));
    check("mid reset operand_2", PW'(bus.alu_operand_2), PW'(1'b0));
    check("mid reset rsp_phv", bus.rsp_phv, PW'(1'b0));
    check("mid reset rsp_timeout", PW'(bus.rsp_timeout), PW'(1'b0));
    tick;
    rst_n = 1'b1;
    bus.alu_container_valid = 1'b1;
    bus.alu_container = 48'h55;
    tick;
    bus.alu_container_valid = 1'b0;
    repeat (TO + 3) begin
      check("post reset rsp_valid", PW'(bus.rsp_valid), PW'(1'b0));
      tick;
    end
    check("post reset req_ready", PW'(bus.req_ready), PW'(1'b1));
    check("post reset rsp_phv", bus.rsp_phv, PW'(1'b0));
    run_vec(vecs[0], "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
